// File: rtl/mic_adc_scan_scheduler_pkg.sv
// Shared definitions for the microphone/analog ADC scan scheduler: FSM encoding,
// frame-rate divider presets and a constant-width helper.
package mic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      PUSH  = 3'd3,
      NEXT  = 3'd4
   } state_e;

   localparam int DEFAULT_DIV_40KHZ = 2499;
   localparam int DEFAULT_DIV_20KHZ = 4999;
   localparam int MIN_DIV           = 3;

   // Index width for n items, never less than 1 so a single channel still has a port.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mic_adc_scan_scheduler_rate_tick.sv
// Frame-period counter: counts 0..max(div_value, MIN_DIV) and emits a one-cycle
// registered tick on each wrap.
module mic_rate_tick
   import mic_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_value,
   output logic             tick
);

   logic [DIV_W-1:0] lim;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   assign lim = (div_value < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_value;

   // A limit that drops below the running count forces a wrap on the next edge.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      tick_d = 1'b0;
      if (!enable) begin
         cnt_d = '0;
      end else if (cnt_q >= lim) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/mic_adc_scan_scheduler.sv
// Scans the enabled ADC channels once per frame tick, lowest index first, and
// streams tagged results; overruns and stuck conversions raise sticky flags.
module mic_adc_scan_scheduler
   import mic_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int CH_W    = 1,
   parameter int DATA_W  = 10,
   parameter int DIV_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DIV_W-1:0]  div_value,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              clr_err,
   output logic              conv_start,
   output logic [CH_W-1:0]   conv_ch,
   input  logic              conv_done,
   input  logic [DATA_W-1:0] conv_data,
   output logic              smp_valid,
   input  logic              smp_ready,
   output logic [DATA_W-1:0] smp_data,
   output logic [CH_W-1:0]   smp_ch,
   output logic              busy,
   output logic              overrun,
   output logic              timeout_err
);

   localparam int TMO_W = clog2(TIMEOUT + 1);

   logic              tick;
   state_e            state_q;
   logic [NUM_CH-1:0] mask_q;
   logic [CH_W-1:0]   cur_ch_q, smp_ch_q;
   logic [DATA_W-1:0] smp_data_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              conv_start_q, smp_valid_q, overrun_q, timeout_q;
   logic [CH_W:0]     first_sel, next_sel;

   mic_rate_tick #(.DIV_W(DIV_W)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .div_value (div_value),
      .tick      (tick)
   );

   // Returns {found, index} of the lowest set mask bit at or above 'from'.
   function automatic logic [CH_W:0] find_next(input logic [NUM_CH-1:0] m, input int from);
      logic [CH_W:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i] && i >= from) r = {1'b1, CH_W'(i)};
      end
      return r;
   endfunction

   assign first_sel = find_next(ch_mask, 0);
   assign next_sel  = find_next(mask_q, int'(cur_ch_q) + 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mask_q       <= '0;
         cur_ch_q     <= '0;
         smp_ch_q     <= '0;
         smp_data_q   <= '0;
         tmo_q        <= '0;
         conv_start_q <= 1'b0;
         smp_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         conv_start_q <= 1'b0;
         // Clear first so a same-cycle error event below overrides it.
         if (clr_err) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
         end
         if (tick && state_q != IDLE) overrun_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (tick && enable && first_sel[CH_W]) begin
                  mask_q       <= ch_mask;
                  cur_ch_q     <= first_sel[CH_W-1:0];
                  conv_start_q <= 1'b1;
                  state_q      <= START;
               end
            end
            START: begin
               tmo_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (conv_done) begin
                  smp_data_q  <= conv_data;
                  smp_ch_q    <= cur_ch_q;
                  smp_valid_q <= 1'b1;
                  state_q     <= PUSH;
               end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  timeout_q <= 1'b1;
                  state_q   <= NEXT;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            PUSH: begin
               if (smp_ready) begin
                  smp_valid_q <= 1'b0;
                  state_q     <= NEXT;
               end
            end
            NEXT: begin
               if (next_sel[CH_W]) begin
                  cur_ch_q     <= next_sel[CH_W-1:0];
                  conv_start_q <= 1'b1;
                  state_q      <= START;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign conv_start  = conv_start_q;
   assign conv_ch     = cur_ch_q;
   assign smp_valid   = smp_valid_q;
   assign smp_data    = smp_data_q;
   assign smp_ch      = smp_ch_q;
   assign busy        = (state_q != IDLE);
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mic_adc_scan_scheduler.sv
// Directed bench for the ADC scan scheduler: a table of single-frame scans plus
// hand-written sequences for stall, timeout, error clearing, reset and tick period.
module tb_mic_adc_scan_scheduler;

   localparam int NUM_CH = 2;
   localparam int CH_W   = 1;
   localparam int DATA_W = 10;
   localparam int DIV_W  = 16;
   localparam int SW     = CH_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [DIV_W-1:0]  div_value;
   logic [NUM_CH-1:0] ch_mask;
   logic              clr_err;
   logic              conv_start;
   logic [CH_W-1:0]   conv_ch;
   logic              conv_done = 1'b0;
   logic [DATA_W-1:0] conv_data = '0;
   logic              smp_valid;
   logic              smp_ready;
   logic [DATA_W-1:0] smp_data;
   logic [CH_W-1:0]   smp_ch;
   logic              busy;
   logic              overrun;
   logic              timeout_err;

   mic_adc_scan_scheduler #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .DIV_W(DIV_W), .TIMEOUT(255)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .div_value(div_value), .ch_mask(ch_mask),
      .clr_err(clr_err), .conv_start(conv_start), .conv_ch(conv_ch), .conv_done(conv_done),
      .conv_data(conv_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
      .smp_data(smp_data), .smp_ch(smp_ch), .busy(busy), .overrun(overrun),
      .timeout_err(timeout_err)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #300us;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // ADC model and stream monitor
   logic              adc_on = 1'b1;
   logic [DATA_W-1:0] adc_val [NUM_CH];
   int                man_req = 0;
   logic [DATA_W-1:0] man_data = '0;
   logic [SW-1:0]     got_q[$];
   logic [CH_W-1:0]   start_q[$];
   logic [SW-1:0]     exp_q[$];

   initial begin
      int man_ack;
      logic [CH_W-1:0] ch;
      man_ack = 0;
      forever begin
         @(negedge clk);
         if (man_req != man_ack) begin
            conv_done = 1'b1;
            conv_data = man_data;
            @(negedge clk);
            conv_done = 1'b0;
            man_ack++;
         end else if (conv_start && adc_on) begin
            ch = conv_ch;
            repeat (4) @(negedge clk);
            conv_done = 1'b1;
            conv_data = adc_val[ch];
            @(negedge clk);
            conv_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (smp_valid && smp_ready) got_q.push_back({smp_ch, smp_data});
      if (conv_start) start_q.push_back(conv_ch);
   end

   // scoreboard helpers
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (conv_start) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (smp_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_tick(input int budget, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         n++;
         if (dut.u_tick.tick) ok = 1'b1;
      end
   endtask

   typedef struct {
      logic [DIV_W-1:0]  div;
      logic [NUM_CH-1:0] mask;
      logic [DATA_W-1:0] d0;
      logic [DATA_W-1:0] d1;
      int                exp_n;
      logic [SW-1:0]     exp_s0;
      logic [SW-1:0]     exp_s1;
   } vec_t;

   vec_t vecs[3];

   initial begin
      bit ok;
      int g0, s0, n, bad;
      logic [DATA_W-1:0] held_d;
      logic [CH_W-1:0]   held_ch;

      vecs[0] = '{div: 16'd9,  mask: 2'b11, d0: 10'h155, d1: 10'h2AA, exp_n: 2,
                  exp_s0: {1'b0, 10'h155}, exp_s1: {1'b1, 10'h2AA}};
      vecs[1] = '{div: 16'd9,  mask: 2'b10, d0: 10'h111, d1: 10'h3A5, exp_n: 1,
                  exp_s0: {1'b1, 10'h3A5}, exp_s1: '0};
      vecs[2] = '{div: 16'd20, mask: 2'b01, d0: 10'h0FF, d1: 10'h001, exp_n: 1,
                  exp_s0: {1'b0, 10'h0FF}, exp_s1: '0};

      rst = 1'b1; enable = 1'b0; div_value = 16'd9; ch_mask = '0; clr_err = 1'b0;
      smp_ready = 1'b1; adc_val[0] = '0; adc_val[1] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {conv_start, conv_ch, smp_valid, smp_data, smp_ch, busy, overrun, timeout_err}, 0);

      // Table: one frame per vector, enable dropped right after the first conversion starts.
      for (int v = 0; v < 3; v++) begin
         div_value = vecs[v].div; ch_mask = vecs[v].mask;
         adc_val[0] = vecs[v].d0; adc_val[1] = vecs[v].d1;
         adc_on = 1'b1; smp_ready = 1'b1;
         @(negedge clk);
         g0 = got_q.size(); s0 = start_q.size();
         enable = 1'b1;
         wait_start(60, ok);
         enable = 1'b0;
         chk($sformatf("v%0d_start_seen", v), ok, 1);
         chk($sformatf("v%0d_first_ch", v), conv_ch, vecs[v].exp_s0[SW-1 -: CH_W]);
         wait_idle(100, ok);
         chk($sformatf("v%0d_idle", v), ok, 1);
         chk($sformatf("v%0d_n_samples", v), got_q.size() - g0, vecs[v].exp_n);
         chk($sformatf("v%0d_n_starts", v), start_q.size() - s0, vecs[v].exp_n);
         for (int k = 0; k < vecs[v].exp_n; k++) exp_q.push_back(k == 0 ? vecs[v].exp_s0 : vecs[v].exp_s1);
         for (int k = 0; exp_q.size() > 0; k++) begin
            chk($sformatf("v%0d_sample%0d", v, k), (got_q.size() > g0 + k) ? 32'(got_q[g0 + k]) : 32'hDEAD, 32'(exp_q.pop_front()));
         end
         chk($sformatf("v%0d_errors", v), {overrun, timeout_err}, 0);
      end

      // Tick period, including the clamp of small divider values.
      ch_mask = '0; div_value = 16'd9; enable = 1'b1;
      wait_tick(40, ok, n);
      wait_tick(40, ok, n);
      chk("period_div9", ok ? n : 0, 10);
      div_value = 16'd0;
      wait_tick(40, ok, n);
      wait_tick(40, ok, n);
      wait_tick(40, ok, n);
      chk("period_div0_clamped", ok ? n : 0, 4);
      enable = 1'b0;

      // Stall: sample held while smp_ready is low across a frame tick.
      div_value = 16'd9; ch_mask = 2'b01; adc_val[0] = 10'h2C3; smp_ready = 1'b0;
      @(negedge clk);
      s0 = start_q.size();
      enable = 1'b1;
      wait_valid(80, ok);
      chk("stall_valid_seen", ok, 1);
      held_d = smp_data; held_ch = smp_ch;
      chk("stall_data", {held_ch, held_d}, {1'b0, 10'h2C3});
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (!smp_valid || smp_data !== held_d || smp_ch !== held_ch) bad++;
      end
      chk("stall_stable", bad, 0);
      chk("stall_no_extra_start", start_q.size() - s0, 1);
      chk("stall_overrun", overrun, 1);
      enable = 1'b0; smp_ready = 1'b1;
      wait_idle(50, ok);
      chk("stall_idle", ok, 1);

      // Timeout on ch0, ch1 still converted.
      ch_mask = 2'b11; adc_on = 1'b0; adc_val[1] = 10'h0F0;
      @(negedge clk);
      g0 = got_q.size(); s0 = start_q.size();
      enable = 1'b1;
      wait_start(60, ok);
      enable = 1'b0;
      chk("tmo_start_seen", ok, 1);
      @(negedge clk);
      adc_on = 1'b1;
      n = 1;
      while (!timeout_err && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", n, 256);
      wait_idle(100, ok);
      chk("tmo_idle", ok, 1);
      chk("tmo_n_samples", got_q.size() - g0, 1);
      chk("tmo_sample", (got_q.size() > g0) ? 32'(got_q[g0]) : 32'hDEAD, {1'b1, 10'h0F0});
      chk("tmo_start_chs", (start_q.size() >= s0 + 2) ? {start_q[s0], start_q[s0 + 1]} : 2'b11, 2'b01);

      // Error clearing: lone clear, then clear colliding with a new overrun.
      ch_mask = 2'b01; smp_ready = 1'b0;
      enable = 1'b1;
      wait_valid(80, ok);
      chk("clr_stalled", ok, 1);
      n = 0;
      while (dut.u_tick.tick && n < 20) begin
         @(negedge clk);
         n++;
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_lone", {overrun, timeout_err}, 0);
      wait_tick(30, ok, n);
      chk("clr_tick_seen", ok, 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_set_wins", overrun, 1);
      enable = 1'b0; smp_ready = 1'b1;
      wait_idle(50, ok);

      // Reset in WAIT, stray conv_done afterwards, then a fresh scan.
      ch_mask = 2'b11; adc_on = 1'b0;
      enable = 1'b1;
      wait_start(60, ok);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_outputs", {conv_start, conv_ch, smp_valid, smp_data, smp_ch, busy, overrun, timeout_err}, 0);
      man_data = 10'h3FF;
      man_req++;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (smp_valid || busy || conv_start) bad++;
      end
      chk("rst_done_ignored", bad, 0);
      adc_on = 1'b1; adc_val[0] = 10'h011; adc_val[1] = 10'h322;
      g0 = got_q.size();
      enable = 1'b1;
      wait_start(60, ok);
      enable = 1'b0;
      chk("rst_fresh_ch0", {ok, conv_ch}, 2'b10);
      wait_idle(100, ok);
      chk("rst_fresh_n", got_q.size() - g0, 2);
      chk("rst_fresh_s1", (got_q.size() >= g0 + 2) ? 32'(got_q[g0 + 1]) : 32'hDEAD, {1'b1, 10'h322});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
